// File: rtl/sdpram_bist_pkg.sv
// Shared types and constants for the simple-dual-port RAM BIST controller.
// Optional feature macro: SDPRAM_BIST_FAIL_LOG_EN (first-failure capture ports).
package sdpram_bist_pkg;

    // Controller run phases
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Pattern select encodings
    localparam logic [1:0] MODE_DESC  = 2'd0;
    localparam logic [1:0] MODE_ADDR  = 2'd1;
    localparam logic [1:0] MODE_CHK   = 2'd2;
    localparam logic [1:0] MODE_NADDR = 2'd3;

    // Mismatch counter width and saturation value
    localparam int unsigned ERR_W   = 3;
    localparam logic [2:0]  ERR_SAT = 3'd7;

endpackage

// File: rtl/sdpram_bist_pattern.sv
// Combinational test pattern generator: data word for a given address and mode.
// Optional feature macro: SDPRAM_BIST_FAIL_LOG_EN (not used in this file).
module sdpram_bist_pattern
    import sdpram_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] pat_c
);

    logic [ADDR_WIDTH-1:0] naddr;

    // Invert in address width first so the zero-extension stays zero
    assign naddr = ~addr;

    // Select the pattern word, truncated or zero-extended to the data width
    always_comb begin
        pat_c = '0;
        case (mode)
            MODE_DESC:  pat_c = {DATA_WIDTH{1'b1}} - DATA_WIDTH'(addr);
            MODE_ADDR:  pat_c = DATA_WIDTH'(addr);
            MODE_CHK: begin
                // Bit 0 set for 0x55 on even addresses, cleared for 0xAA on odd
                for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                    pat_c[i] = addr[0] ^ ~i[0];
                end
            end
            MODE_NADDR: pat_c = DATA_WIDTH'(naddr);
            default:    pat_c = '0;
        endcase
    end

endmodule

// File: rtl/sdpram_bist_ctrl.sv
// March-style write-then-read BIST controller for a simple-dual-port RAM.
// Optional feature macro: SDPRAM_BIST_FAIL_LOG_EN adds fail_valid/fail_addr/fail_data,
// which hold the address and read data of the first mismatch of a run.
module sdpram_bist_ctrl
    import sdpram_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BE_WIDTH   = 1,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_cnt,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [BE_WIDTH-1:0]   wr_byte_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
`ifdef SDPRAM_BIST_FAIL_LOG_EN
    ,
    output logic                  fail_valid,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
`endif
);

    // Counter is one bit wider than the address so reaching 2**ADDR_WIDTH is visible
    localparam logic [ADDR_WIDTH:0] CNT_END    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] DRAIN_LAST = (ADDR_WIDTH+1)'(RD_LATENCY - 1);

    state_t                state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [1:0]            mode_q;

    logic                  launch_c;
    logic [1:0]            wr_mode_c;
    logic [ADDR_WIDTH-1:0] wr_pat_addr_c;
    logic [DATA_WIDTH-1:0] wr_pat_c;
    logic [DATA_WIDTH-1:0] exp_pat_c;
    logic                  mismatch_c;
    logic [ERR_W-1:0]      err_nxt_c;

    logic [RD_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_exp [RD_LATENCY];
`ifdef SDPRAM_BIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] pipe_addr [RD_LATENCY];
`endif

    // A start is only honoured between runs
    assign launch_c = start && ((state == IDLE) || (state == DONE));

    // Address 0 is issued on the launch edge, before mode_q holds the new mode
    assign wr_mode_c     = launch_c ? mode : mode_q;
    assign wr_pat_addr_c = (state == WRITE) ? cnt[ADDR_WIDTH-1:0] : '0;

    sdpram_bist_pattern #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_pat (
        .addr  (wr_pat_addr_c),
        .mode  (wr_mode_c),
        .pat_c (wr_pat_c)
    );

    sdpram_bist_pattern #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_exp_pat (
        .addr  (rd_addr),
        .mode  (mode_q),
        .pat_c (exp_pat_c)
    );

    // Compare the delayed expectation against returning read data
    assign mismatch_c = pipe_vld[RD_LATENCY-1] && (rd_data != pipe_exp[RD_LATENCY-1]);
    assign err_nxt_c  = (mismatch_c && (err_cnt != ERR_SAT)) ? err_cnt + 3'd1 : err_cnt;

    // Run sequencer with registered RAM controls and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mode_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_byte_en <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
        end else begin
            err_cnt <= err_nxt_c;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WRITE;
                        mode_q     <= mode;
                        err_cnt    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        wr_en      <= 1'b1;
                        wr_byte_en <= '1;
                        wr_addr    <= '0;
                        wr_data    <= wr_pat_c;
                        cnt        <= CNT_ONE;
                    end
                end
                WRITE: begin
                    if (cnt == CNT_END) begin
                        state      <= READ;
                        wr_en      <= 1'b0;
                        wr_byte_en <= '0;
                        rd_en      <= 1'b1;
                        rd_addr    <= '0;
                        cnt        <= CNT_ONE;
                    end else begin
                        wr_addr <= cnt[ADDR_WIDTH-1:0];
                        wr_data <= wr_pat_c;
                        cnt     <= cnt + 1'b1;
                    end
                end
                READ: begin
                    if (cnt == CNT_END) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        rd_addr <= cnt[ADDR_WIDTH-1:0];
                        cnt     <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt_c == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Expected-data pipeline matching the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe_exp[i] <= '0;
`ifdef SDPRAM_BIST_FAIL_LOG_EN
                pipe_addr[i] <= '0;
`endif
            end
        end else begin
            pipe_vld[0] <= rd_en;
            pipe_exp[0] <= exp_pat_c;
`ifdef SDPRAM_BIST_FAIL_LOG_EN
            pipe_addr[0] <= rd_addr;
`endif
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
`ifdef SDPRAM_BIST_FAIL_LOG_EN
                pipe_addr[i] <= pipe_addr[i-1];
`endif
            end
        end
    end

`ifdef SDPRAM_BIST_FAIL_LOG_EN
    // Capture the first mismatch of a run; cleared by the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else if (launch_c) begin
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else if (mismatch_c && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_addr  <= pipe_addr[RD_LATENCY-1];
            fail_data  <= rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_sdpram_bist_ctrl.sv
// Self-checking bench for sdpram_bist_ctrl: three configurations, behavioural RAMs
// with fault injection, table-driven runs, randomized faults and corner sequences.
// Optional feature macro: SDPRAM_BIST_FAIL_LOG_EN (fail log checks enabled with it).
module tb_sdpram_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Instance A: 1024 x 8, latency 1, fault-injecting RAM
    logic start_a, busy_a, done_a, pass_a, wr_en_a, rd_en_a;
    logic [1:0] mode_a;
    logic [2:0] err_a;
    logic [9:0] wr_addr_a, rd_addr_a;
    logic [7:0] wr_data_a, rd_data_a;
    logic [0:0] wr_be_a;
    // Instance B: 1024 x 8, latency 2 (RAM output register), optional extra delay
    logic start_b, busy_b, done_b, pass_b, wr_en_b, rd_en_b;
    logic [1:0] mode_b;
    logic [2:0] err_b;
    logic [9:0] wr_addr_b, rd_addr_b;
    logic [7:0] wr_data_b, rd_data_b;
    logic [0:0] wr_be_b;
    // Instance C: 512 x 18, two 9-bit lanes, latency 1
    logic start_c, busy_c, done_c, pass_c, wr_en_c, rd_en_c;
    logic [1:0] mode_c;
    logic [2:0] err_c;
    logic [8:0] wr_addr_c, rd_addr_c;
    logic [17:0] wr_data_c, rd_data_c;
    logic [1:0] wr_be_c;
`ifdef SDPRAM_BIST_FAIL_LOG_EN
    logic fv_a, fv_b, fv_c;
    logic [9:0] fa_a, fa_b;
    logic [8:0] fa_c;
    logic [7:0] fd_a, fd_b;
    logic [17:0] fd_c;
`endif

    sdpram_bist_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .BE_WIDTH(1), .RD_LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_byte_en(wr_be_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a)
`ifdef SDPRAM_BIST_FAIL_LOG_EN
        , .fail_valid(fv_a), .fail_addr(fa_a), .fail_data(fd_a)
`endif
    );

    sdpram_bist_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .BE_WIDTH(1), .RD_LATENCY(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_byte_en(wr_be_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b)
`ifdef SDPRAM_BIST_FAIL_LOG_EN
        , .fail_valid(fv_b), .fail_addr(fa_b), .fail_data(fd_b)
`endif
    );

    sdpram_bist_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(18), .BE_WIDTH(2), .RD_LATENCY(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .mode(mode_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
        .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .wr_byte_en(wr_be_c),
        .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c)
`ifdef SDPRAM_BIST_FAIL_LOG_EN
        , .fail_valid(fv_c), .fail_addr(fa_c), .fail_data(fd_c)
`endif
    );

    // Pattern rules written directly from the pattern definitions
    function automatic longint ref_pat(int aw, int dw, int m, int a);
        longint mask = (longint'(1) << dw) - 1;
        case (m)
            0:       return (mask - longint'(a)) & mask;
            1:       return longint'(a) & mask;
            2:       return ((a % 2 == 0) ? 64'h15555 : 64'h2AAAA) & mask;
            default: return (~longint'(a) & ((longint'(1) << aw) - 1)) & mask;
        endcase
    endfunction

    // RAM A with up to 8 stuck-at bits applied on read
    logic [7:0] mem_a [1024];
    int   nf_a = 0;
    int   f_addr [8];
    int   f_bit  [8];
    logic f_val  [8];

    function automatic logic [7:0] faulty_a(logic [9:0] a);
        logic [7:0] d = mem_a[a];
        for (int i = 0; i < nf_a; i++)
            if (f_addr[i] == int'(a)) d[f_bit[i]] = f_val[i];
        return d;
    endfunction

    always @(posedge clk) begin
        if (wr_en_a && wr_be_a[0]) mem_a[wr_addr_a] <= wr_data_a;
        if (rd_en_a) rd_data_a <= faulty_a(rd_addr_a);
    end

    // RAM B: registered output, optionally one stage too many
    logic [7:0] mem_b [1024];
    logic [7:0] s1_b, s2_b, s3_b;
    logic dly3_b;
    always @(posedge clk) begin
        if (wr_en_b && wr_be_b[0]) mem_b[wr_addr_b] <= wr_data_b;
        if (rd_en_b) s1_b <= mem_b[rd_addr_b];
        s2_b <= s1_b;
        s3_b <= s2_b;
    end
    assign rd_data_b = dly3_b ? s3_b : s2_b;

    // RAM C: two 9-bit byte lanes
    logic [17:0] mem_c [512];
    always @(posedge clk) begin
        if (wr_en_c && wr_be_c[0]) mem_c[wr_addr_c][8:0]  <= wr_data_c[8:0];
        if (wr_en_c && wr_be_c[1]) mem_c[wr_addr_c][17:9] <= wr_data_c[17:9];
        if (rd_en_c) rd_data_c <= mem_c[rd_addr_c];
    end

    // Cumulative bus monitors, sampled mid-cycle
    int mode_exp_a = 0;
    int mode_exp_c = 0;
    int wr_cnt_a = 0, rd_cnt_a = 0, wr_bad_a = 0, ord_bad_a = 0, ovl_a = 0;
    int wr_cnt_c = 0, wr_bad_c = 0, be_bad_c = 0, ovl_c = 0;
    int wr_nxt_a = 0, rd_nxt_a = 0;
    logic [7:0]  wd0_a = '0, wd5_a = '0;
    logic [17:0] wd0_c = '0;

    always @(negedge clk) begin
        if (wr_en_a && rd_en_a) ovl_a <= ovl_a + 1;
        if (wr_en_a) begin
            wr_cnt_a <= wr_cnt_a + 1;
            if (longint'(wr_data_a) != ref_pat(10, 8, mode_exp_a, int'(wr_addr_a))) wr_bad_a <= wr_bad_a + 1;
            if (int'(wr_addr_a) != wr_nxt_a) ord_bad_a <= ord_bad_a + 1;
            wr_nxt_a <= int'(wr_addr_a) + 1;
            if (wr_addr_a == 10'd0) wd0_a <= wr_data_a;
            if (wr_addr_a == 10'd5) wd5_a <= wr_data_a;
        end else begin
            wr_nxt_a <= 0;
        end
        if (rd_en_a) begin
            rd_cnt_a <= rd_cnt_a + 1;
            if (int'(rd_addr_a) != rd_nxt_a) ord_bad_a <= ord_bad_a + 1;
            rd_nxt_a <= int'(rd_addr_a) + 1;
        end else begin
            rd_nxt_a <= 0;
        end
    end

    always @(negedge clk) begin
        if (wr_en_c && rd_en_c) ovl_c <= ovl_c + 1;
        if (wr_en_c) begin
            wr_cnt_c <= wr_cnt_c + 1;
            if (wr_be_c != 2'b11) be_bad_c <= be_bad_c + 1;
            if (longint'(wr_data_c) != ref_pat(9, 18, mode_exp_c, int'(wr_addr_c))) wr_bad_c <= wr_bad_c + 1;
            if (wr_addr_c == 9'd0) wd0_c <= wr_data_c;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input int sel, input logic v, input logic [1:0] m);
        case (sel)
            0:       begin start_a = v; mode_a = m; end
            1:       begin start_b = v; mode_b = m; end
            default: begin start_c = v; mode_c = m; end
        endcase
    endtask

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
    endfunction

    // Pulse start, optionally pulse it again at cycle pulse_at, count cycles to done
    task automatic run(input int sel, input logic [1:0] m, input int pulse_at, output int cycles);
        if (sel == 0) mode_exp_a = int'(m);
        if (sel == 2) mode_exp_c = int'(m);
        @(negedge clk);
        drive_start(sel, 1'b1, m);
        cycles = 0;
        for (int n = 1; n <= 6000; n++) begin
            @(negedge clk);
            if (n == 1) drive_start(sel, 1'b0, m);
            if (pulse_at != 0 && n == pulse_at) drive_start(sel, 1'b1, ~m);
            if (pulse_at != 0 && n == pulse_at + 1) drive_start(sel, 1'b0, m);
            if (done_of(sel)) begin
                cycles = n;
                break;
            end
        end
        if (cycles == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL run timeout: instance %0d never reached done within 6000 cycles", sel);
        end
    endtask

    // Expected outcome of a run on RAM A from the injected faults
    task automatic predict_a(input int m, output int e, output int fa, output int fd);
        longint exp, got;
        e = 0; fa = 0; fd = 0;
        for (int a = 0; a < 1024; a++) begin
            exp = ref_pat(10, 8, m, a);
            got = exp;
            for (int i = 0; i < nf_a; i++)
                if (f_addr[i] == a) begin
                    if (f_val[i]) got = got | (longint'(1) << f_bit[i]);
                    else          got = got & ~(longint'(1) << f_bit[i]);
                end
            if (got != exp) begin
                if (e == 0) begin fa = a; fd = int'(got); end
                e++;
            end
        end
        if (e > 7) e = 7;
    endtask

    // Check a completed run on instance A against expected results
    task automatic check_a(input string tag, input int e, input logic p, input int fa, input int fd,
                           input int cyc, input int w0, input int r0, input int b0, input int o0, input int v0);
        check({tag, " err_cnt"}, longint'(err_a), longint'(e));
        check({tag, " pass"}, longint'(pass_a), longint'(p));
        check({tag, " done/busy"}, longint'({done_a, busy_a}), 2);
        check({tag, " cycles"}, longint'(cyc), 2050);
        check({tag, " write count"}, longint'(wr_cnt_a - w0), 1024);
        check({tag, " read count"}, longint'(rd_cnt_a - r0), 1024);
        check({tag, " write data errors"}, longint'(wr_bad_a - b0), 0);
        check({tag, " wr/rd overlap or order"}, longint'(ovl_a - o0 + ord_bad_a - v0), 0);
`ifdef SDPRAM_BIST_FAIL_LOG_EN
        check({tag, " fail_valid"}, longint'(fv_a), longint'(e != 0));
        if (e != 0) begin
            check({tag, " fail_addr"}, longint'(fa_a), longint'(fa));
            check({tag, " fail_data"}, longint'(fd_a), longint'(fd));
        end
`else
        if (fa < 0 || fd < 0) $display("note: negative fail expectation");
`endif
    endtask

    typedef struct {
        logic [1:0] mode;
        int         nf;
        int         faddr;
        int         fbit;
        logic       fval;
        int         exp_err;
        logic       exp_pass;
        int         exp_faddr;
        int         exp_fdata;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int cyc, e, fa, fd, w0, r0, b0, o0, v0;
        logic [1:0] m;

        tbl[0] = '{2'd0, 0, 0,     0, 1'b0, 0, 1'b1, 0,     0};
        tbl[1] = '{2'd1, 1, 'h00F, 3, 1'b0, 1, 1'b0, 'h00F, 'h07};
        tbl[2] = '{2'd1, 1, 'h00F, 3, 1'b1, 0, 1'b1, 0,     0};
        tbl[3] = '{2'd2, 1, 'h003, 0, 1'b1, 1, 1'b0, 'h003, 'hAB};
        tbl[4] = '{2'd3, 1, 'h100, 7, 1'b0, 1, 1'b0, 'h100, 'h7F};
        tbl[5] = '{2'd0, 1, 'h005, 0, 1'b1, 1, 1'b0, 'h005, 'hFB};
        tbl[6] = '{2'd0, 1, 'h3FF, 7, 1'b1, 1, 1'b0, 'h3FF, 'h80};
        tbl[7] = '{2'd1, 1, 'h000, 0, 1'b1, 1, 1'b0, 'h000, 'h01};

        rst_n = 1'b0;
        start_a = 0; start_b = 0; start_c = 0;
        mode_a = 0; mode_b = 0; mode_c = 0;
        dly3_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs A", longint'({busy_a, done_a, pass_a, err_a, wr_en_a, wr_addr_a, wr_data_a, wr_be_a, rd_en_a, rd_addr_a}), 0);
        check("reset outputs B", longint'({busy_b, done_b, pass_b, err_b, wr_en_b, wr_addr_b, wr_data_b, wr_be_b, rd_en_b, rd_addr_b}), 0);
        check("reset outputs C", longint'({busy_c, done_c, pass_c, err_c, wr_en_c, wr_addr_c, wr_data_c, wr_be_c, rd_en_c, rd_addr_c}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Descending pattern, clean RAM, spot-check written words
        nf_a = 0;
        w0 = wr_cnt_a; r0 = rd_cnt_a; b0 = wr_bad_a; o0 = ovl_a; v0 = ord_bad_a;
        run(0, 2'd0, 0, cyc);
        check("mode0 wr_data[0]", longint'(wd0_a), 'hFF);
        check("mode0 wr_data[5]", longint'(wd5_a), 'hFA);
        check_a("mode0 clean", 0, 1'b1, 0, 0, cyc, w0, r0, b0, o0, v0);

        // Table of single stuck-at faults with hand-derived results
        for (int k = 0; k < 8; k++) begin
            nf_a = tbl[k].nf;
            f_addr[0] = tbl[k].faddr; f_bit[0] = tbl[k].fbit; f_val[0] = tbl[k].fval;
            w0 = wr_cnt_a; r0 = rd_cnt_a; b0 = wr_bad_a; o0 = ovl_a; v0 = ord_bad_a;
            run(0, tbl[k].mode, 0, cyc);
            check_a($sformatf("vec%0d", k), tbl[k].exp_err, tbl[k].exp_pass, tbl[k].exp_faddr,
                    tbl[k].exp_fdata, cyc, w0, r0, b0, o0, v0);
        end

        // Random multi-fault runs against the reference model
        for (int k = 0; k < 5; k++) begin
            m = 2'($urandom_range(0, 3));
            nf_a = $urandom_range(0, 8);
            for (int i = 0; i < 8; i++) begin
                f_addr[i] = $urandom_range(0, 1023);
                f_bit[i]  = $urandom_range(0, 7);
                f_val[i]  = 1'($urandom_range(0, 1));
            end
            predict_a(int'(m), e, fa, fd);
            w0 = wr_cnt_a; r0 = rd_cnt_a; b0 = wr_bad_a; o0 = ovl_a; v0 = ord_bad_a;
            run(0, m, 0, cyc);
            check_a($sformatf("rand%0d", k), e, (e == 0), fa, fd, cyc, w0, r0, b0, o0, v0);
        end
        nf_a = 0;

        // Start pulsed mid-WRITE must not restart or lengthen the run
        w0 = wr_cnt_a; r0 = rd_cnt_a; b0 = wr_bad_a; o0 = ovl_a; v0 = ord_bad_a;
        run(0, 2'd1, 10, cyc);
        check_a("start in WRITE", 0, 1'b1, 0, 0, cyc, w0, r0, b0, o0, v0);

        // Reset in the middle of READ aborts immediately and silently
        mode_exp_a = 0;
        @(negedge clk);
        drive_start(0, 1'b1, 2'd0);
        @(negedge clk);
        drive_start(0, 1'b0, 2'd0);
        cyc = 0;
        for (int n = 0; n < 3000; n++) begin
            if (rd_en_a && rd_addr_a == 10'd100) begin cyc = 1; break; end
            @(negedge clk);
        end
        check("reached READ address 100", longint'(cyc), 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset mid-READ outputs", longint'({busy_a, done_a, pass_a, err_a, wr_en_a, wr_addr_a, wr_data_a, wr_be_a, rd_en_a, rd_addr_a}), 0);
`ifdef SDPRAM_BIST_FAIL_LOG_EN
        check("reset mid-READ fail log", longint'({fv_a, fa_a, fd_a}), 0);
`endif
        w0 = wr_cnt_a; r0 = rd_cnt_a;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no RAM access after abort", longint'(wr_cnt_a - w0 + rd_cnt_a - r0), 0);
        check("idle after abort", longint'({busy_a, done_a, wr_en_a, rd_en_a}), 0);
        w0 = wr_cnt_a; r0 = rd_cnt_a; b0 = wr_bad_a; o0 = ovl_a; v0 = ord_bad_a;
        run(0, 2'd0, 0, cyc);
        check_a("after abort", 0, 1'b1, 0, 0, cyc, w0, r0, b0, o0, v0);

        // Latency-2 RAM, checkerboard, then one cycle too slow
        dly3_b = 1'b0;
        run(1, 2'd2, 0, cyc);
        check("lat2 cycles", longint'(cyc), 2051);
        check("lat2 pass", longint'(pass_b), 1);
        check("lat2 err_cnt", longint'(err_b), 0);
        dly3_b = 1'b1;
        run(1, 2'd2, 0, cyc);
        check("lat3 err_cnt saturated", longint'(err_b), 7);
        check("lat3 pass", longint'(pass_b), 0);
        check("lat3 done", longint'(done_b), 1);

        // 512 x 18 with two 9-bit lanes, inverted-address pattern
        w0 = wr_cnt_c; b0 = be_bad_c; o0 = ovl_c; v0 = wr_bad_c;
        run(2, 2'd3, 0, cyc);
        check("x18 cycles", longint'(cyc), 1026);
        check("x18 wr_data[0]", longint'(wd0_c), 'h001FF);
        check("x18 byte enables", longint'(be_bad_c - b0), 0);
        check("x18 write count", longint'(wr_cnt_c - w0), 512);
        check("x18 write data errors", longint'(wr_bad_c - v0 + ovl_c - o0), 0);
        check("x18 pass", longint'(pass_c), 1);
        check("x18 err_cnt", longint'(err_c), 0);
        run(2, 2'd2, 0, cyc);
        check("x18 checkerboard pass", longint'(pass_c), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
